// File: rtl/gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner
//
// Purpose: conditions GPIO_WIDTH asynchronous input pins. Each pin is brought
// into the clock domain by a two-flop synchroniser. An optional per-channel
// debounce counter accepts a new level only after DEBOUNCE_CYCLES consecutive
// cycles at that level. Qualified edges of the clean level set sticky pending
// flags, and irq is their OR.
//
// Build option: define GPIO_DEBOUNCE_EN to include the debounce counters.
// Without it, gpio_clean follows the synchroniser output directly and
// DEBOUNCE_CYCLES has no effect on behaviour.
//
// Parameters:
//   GPIO_WIDTH       number of independent channels (>= 1)
//   DEBOUNCE_CYCLES  stable cycles required to accept a new level (>= 1)
//
// Ports:
//   clock          in   single clock; all state changes on its rising edge
//   reset          in   synchronous, active-high reset
//   gpio_raw       in   [GPIO_WIDTH] asynchronous pin levels
//   rise_en        in   [GPIO_WIDTH] rising-edge event enable
//   fall_en        in   [GPIO_WIDTH] falling-edge event enable
//   pending_clear  in   [GPIO_WIDTH] one-cycle clear strobe for pending
//   gpio_clean     out  [GPIO_WIDTH] synchronised, debounced level
//   pending        out  [GPIO_WIDTH] sticky edge-event flags
//   irq            out  OR of pending
// -----------------------------------------------------------------------------
module gpio_input_conditioner #(
  parameter int GPIO_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] gpio_raw,
  input  logic [GPIO_WIDTH-1:0] rise_en,
  input  logic [GPIO_WIDTH-1:0] fall_en,
  input  logic [GPIO_WIDTH-1:0] pending_clear,
  output logic [GPIO_WIDTH-1:0] gpio_clean,
  output logic [GPIO_WIDTH-1:0] pending,
  output logic                  irq
);

  if (GPIO_WIDTH < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("gpio_input_conditioner: GPIO_WIDTH and DEBOUNCE_CYCLES must be >= 1");
  end

  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;
  logic [GPIO_WIDTH-1:0] clean_q, clean_d;
  logic [GPIO_WIDTH-1:0] clean_prev_q;
  logic [GPIO_WIDTH-1:0] pending_q, pending_d;
  logic [GPIO_WIDTH-1:0] rise_ev, fall_ev;

  // Synchroniser and edge-history registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      clean_q      <= '0;
      clean_prev_q <= '0;
      pending_q    <= '0;
    end else begin
      sync1_q      <= gpio_raw;
      sync2_q      <= sync1_q;
      clean_q      <= clean_d;
      clean_prev_q <= clean_q;
      pending_q    <= pending_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  // Counter is sized for DEBOUNCE_CYCLES, but it never passes
  // DEBOUNCE_CYCLES-1, so it cannot wrap.
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q [GPIO_WIDTH];
  logic [CW-1:0] cnt_d [GPIO_WIDTH];

  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      cnt_d[i] = '0;
      // Any cycle at which sync2 matches the current clean level ends a
      // candidate change, so a short glitch leaves the count at zero.
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          clean_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  always_comb begin
    clean_d = sync2_q;
  end
`endif

  // A change of the clean level is visible one edge later as a difference
  // between clean_q and clean_prev_q. A new event takes priority over a clear
  // strobe that arrives in the same cycle, so the event is never lost.
  always_comb begin
    rise_ev   = clean_q & ~clean_prev_q & rise_en;
    fall_ev   = ~clean_q & clean_prev_q & fall_en;
    pending_d = (pending_q & ~pending_clear) | rise_ev | fall_ev;
  end

  assign gpio_clean = clean_q;
  assign pending    = pending_q;
  assign irq        = |pending_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_gpio_input_conditioner
//
// Bench for gpio_input_conditioner with GPIO_WIDTH=4 and DEBOUNCE_CYCLES=4.
// A cycle model built from the requirements predicts {gpio_clean, pending, irq}
// after every rising edge. Each prediction goes into exp_q and is popped and
// compared at the following falling edge. Directed scenarios add fixed-value
// checks of latency, glitch rejection, pending set/clear priority and reset.
// Works with or without GPIO_DEBOUNCE_EN defined.
// -----------------------------------------------------------------------------
module tb_gpio_input_conditioner;

  localparam int GW = 4;
  localparam int DC = 4;
  localparam int W  = 2 * GW + 1;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = DC + 1;
`else
  localparam int LAT = 2;
`endif

  // Clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [GW-1:0] gpio_raw, rise_en, fall_en, pending_clear;
  logic [GW-1:0] gpio_clean, pending;
  logic          irq;

  gpio_input_conditioner #(
    .GPIO_WIDTH      (GW),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .gpio_raw      (gpio_raw),
    .rise_en       (rise_en),
    .fall_en       (fall_en),
    .pending_clear (pending_clear),
    .gpio_clean    (gpio_clean),
    .pending       (pending),
    .irq           (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [GW-1:0] m_s1, m_s2, m_clean, m_prev, m_pend;
  int            m_cnt [GW];

  task automatic model_step();
    logic [GW-1:0] nclean;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_prev = '0; m_pend = '0;
      for (int i = 0; i < GW; i++) m_cnt[i] = 0;
    end else begin
      nclean = m_clean;
`ifdef GPIO_DEBOUNCE_EN
      for (int i = 0; i < GW; i++) begin
        if (m_s2[i] == m_clean[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == DC - 1) begin
          nclean[i] = m_s2[i];
          m_cnt[i]  = 0;
        end else m_cnt[i] = m_cnt[i] + 1;
      end
`else
      nclean = m_s2;
`endif
      m_pend  = (m_pend & ~pending_clear) | (rise_en & m_clean & ~m_prev)
              | (fall_en & ~m_clean & m_prev);
      m_prev  = m_clean;
      m_clean = nclean;
      m_s2    = m_s1;
      m_s1    = gpio_raw;
    end
  endtask

  // One clock: the model predicts at the rising edge, the prediction is
  // queued, and the DUT outputs are compared at the falling edge.
  task automatic cycle();
    logic [W-1:0] e;
    @(posedge clock);
    model_step();
    exp_q.push_back({m_clean, m_pend, |m_pend});
    @(negedge clock);
    e = exp_q.pop_front();
    check("scoreboard", {gpio_clean, pending, irq}, e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bit seen;
    reset = 1'b1; gpio_raw = '0; rise_en = '0; fall_en = '0; pending_clear = '0;
    m_s1 = 'x; m_s2 = 'x; m_clean = 'x; m_prev = 'x; m_pend = 'x;
    @(negedge clock);
    run(2);
    check("reset_clean", gpio_clean, 0);
    check("reset_pending", pending, 0);
    check("reset_irq", irq, 0);
    reset = 1'b0;
    run(3);

    // Latency on channel 0: sync1 captures the new level at edge 0
    gpio_raw[0] = 1'b1;
    for (int k = 0; k <= LAT; k++) begin
      cycle();
      check("lat_clean0", gpio_clean[0], (k >= LAT));
    end
    gpio_raw[0] = 1'b0;
    run(LAT + 3);
    check("lat_fall_clean0", gpio_clean[0], 0);

    // Short glitch on channel 1 (3 cycles high)
    rise_en = 4'b0010;
    gpio_raw[1] = 1'b1;
    run(3);
    gpio_raw[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
`ifdef GPIO_DEBOUNCE_EN
      check("glitch_clean1", gpio_clean[1], 0);
      check("glitch_pending", pending, 0);
      check("glitch_irq", irq, 0);
`endif
    end
    rise_en = '0;
    pending_clear = '1;
    cycle();
    pending_clear = '0;
    check("clr_all", pending, 0);

    // Rising event on channel 2, then clear behaviour
    rise_en = 4'b0100;
    gpio_raw[2] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      if (gpio_clean[2]) seen = 1'b1;
    end
    if (!seen) check("rise2_timeout", 0, 1);
    check("rise2_pending_before", pending, 0);
    cycle();
    check("rise2_pending", pending, 4'b0100);
    check("rise2_irq", irq, 1);
    rise_en = '0;
    cycle();
    check("en_off_keeps", pending, 4'b0100);
    pending_clear = 4'b0001;
    cycle();
    check("clr_nonpending", pending, 4'b0100);
    pending_clear = 4'b0100;
    cycle();
    pending_clear = '0;
    check("clr2_pending", pending, 0);
    check("clr2_irq", irq, 0);

    // Falling event on channel 3 with a simultaneous clear
    gpio_raw[3] = 1'b1;
    run(LAT + 3);
    check("ch3_high", gpio_clean[3], 1);
    fall_en = 4'b1000;
    gpio_raw[3] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      if (!gpio_clean[3]) seen = 1'b1;
    end
    if (!seen) check("fall3_timeout", 0, 1);
    pending_clear = 4'b1000;
    cycle();
    check("set_wins3", pending[3], 1);
    cycle();
    pending_clear = '0;
    check("clr3", pending[3], 0);
    fall_en = '0;

    // Reset in the middle of a qualifying change on channel 0
    gpio_raw = '0;
    run(LAT + 3);
    gpio_raw[0] = 1'b1;
    rise_en = 4'b0001;
    run(2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midrst_clean", gpio_clean, 0);
    check("midrst_pending", pending, 0);
    check("midrst_irq", irq, 0);
    for (int k = 0; k <= LAT; k++) begin
      cycle();
      check("rst_requal_clean0", gpio_clean[0], (k >= LAT));
    end
    cycle();
    check("rst_rise_pending", pending, 4'b0001);
    pending_clear = 4'b0001;
    rise_en = '0;
    cycle();
    pending_clear = '0;
    gpio_raw = '0;
    run(LAT + 3);

`ifndef GPIO_DEBOUNCE_EN
    // A 1-cycle pulse passes through without debounce
    rise_en = 4'b0001;
    gpio_raw[0] = 1'b1;
    cycle();
    gpio_raw[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      check("pulse_clean0", gpio_clean[0], (k == 2));
    end
    check("pulse_pending0", pending[0], 1);
    rise_en = '0;
    pending_clear = '1;
    cycle();
    pending_clear = '0;
`endif

    // Random traffic, checked only by the scoreboard
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < GW; i++) begin
        if ($urandom_range(0, 5) == 0) gpio_raw[i] = ~gpio_raw[i];
        pending_clear[i] = ($urandom_range(0, 7) == 0);
      end
      if (c % 25 == 0) begin
        rise_en = 4'($urandom_range(0, 15));
        fall_en = 4'($urandom_range(0, 15));
      end
      if (c == 150) reset = 1'b1;
      cycle();
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Upper bound on simulated time in case a task never returns.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gpio_input_conditioner.md
GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 8, number of independent input channels (>=1).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable cycles required to accept a new level (>=1).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port gpio_raw  input  GPIO_WIDTH  asynchronous pin levels.
REQ-006 SHALL have port rise_en  input  GPIO_WIDTH  per-channel rising-edge event enable.
REQ-007 SHALL have port fall_en  input  GPIO_WIDTH  per-channel falling-edge event enable.
REQ-008 SHALL have port pending_clear  input  GPIO_WIDTH  per-channel one-cycle clear strobe for pending.
REQ-009 SHALL have port gpio_clean  output  GPIO_WIDTH  synchronised, debounced level.
REQ-010 SHALL have port pending  output  GPIO_WIDTH  sticky per-channel edge-event flags.
REQ-011 SHALL have port irq  output  1  OR-reduction of pending.

Function
REQ-012 Each channel SHALL pass gpio_raw through a two-flop synchroniser (sync1, sync2).
REQ-013 Each channel SHALL keep a counter of width clog2(DEBOUNCE_CYCLES+1) bits, no wrap possible.
REQ-014 Per edge: if sync2 == gpio_clean, counter <= 0; else if counter == DEBOUNCE_CYCLES-1, gpio_clean <= sync2 and counter <= 0; else counter <= counter+1.
REQ-015 Latency: gpio_clean SHALL change exactly DEBOUNCE_CYCLES+1 rising edges after the edge at which sync1 first captures the new raw level, provided raw stays stable.
REQ-016 A raw excursion yielding fewer than DEBOUNCE_CYCLES consecutive differing sync2 cycles SHALL leave gpio_clean unchanged and return counter to 0.
REQ-017 A 0->1 change of gpio_clean[i] with rise_en[i]=1 SHALL set pending[i] on the next edge; a 1->0 change with fall_en[i]=1 likewise.
REQ-018 pending[i] SHALL clear on the edge where pending_clear[i]=1; simultaneous set and clear SHALL leave pending[i]=1 (set wins).
REQ-019 Deasserting rise_en/fall_en SHALL NOT clear an already-set pending bit; clear of a non-pending bit SHALL have no effect.
REQ-020 irq SHALL be combinational OR of the pending register, asserted in the same cycle pending becomes non-zero.
REQ-021 Channels SHALL be fully independent; no cross-channel interaction.

Reset
REQ-022 On reset high at a clock edge, sync1, sync2, counters, gpio_clean and pending SHALL all become 0; irq SHALL be 0.
REQ-023 Reset asserted mid-debounce SHALL discard the partial count; qualification restarts after release.
REQ-024 A pin held high through reset SHALL qualify after release and, with rise_en set, SHALL produce a rising event (intended; software clears it).

Configuration
REQ-025 Macro GPIO_DEBOUNCE_EN defined: debounce counters present per REQ-013..REQ-016.
REQ-026 Macro GPIO_DEBOUNCE_EN undefined: counters omitted, gpio_clean <= sync2 every edge (change 2 edges after sync1 capture), DEBOUNCE_CYCLES ignored; edge/pending/irq logic unchanged.

Verification (GPIO_WIDTH=4, DEBOUNCE_CYCLES=4, macro defined unless noted)
REQ-027 gpio_raw[0] 0->1 captured by sync1 at edge 0, held -> gpio_clean[0]=1 after edge 5, not before.
REQ-028 gpio_raw[1] high for 3 cycles then low -> gpio_clean[1] stays 0, pending stays 0, irq 0.
REQ-029 rise_en=4'b0100, gpio_raw[2] rises and qualifies -> pending=4'b0100 one edge after gpio_clean[2] rises, irq=1; pending_clear=4'b0100 -> pending=0, irq=0.
REQ-030 fall_en[3]=1, pending_clear[3] pulsed in the same cycle as the falling-event set -> pending[3]=1 (set wins).
REQ-031 reset pulsed 2 cycles into a qualifying change on channel 0 -> all outputs 0; raw still high -> gpio_clean[0]=1 at edge 5 after release capture.
REQ-032 Macro undefined: gpio_raw[0] 1-cycle pulse -> gpio_clean[0] shows a 1-cycle pulse 2 edges after sync1 capture; rise_en[0]=1 -> pending[0]=1.
